// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : reset_sequencer
//  Purpose  : Releases three active-low domain resets in order after PLL lock,
//             with a four-phase soft-reset handshake to re-run the sequence.
//  Revision : 1.0  initial release
// ============================================================================
module reset_sequencer #(
    parameter int          CNT_W    = 27,
    parameter int unsigned DLY0     = 1048576,
    parameter int unsigned DLY1     = 32505856,
    parameter int unsigned DLY2     = 33554432,
    parameter int unsigned HOLD_CYC = 16
) (
    input  logic       iCLK,
    input  logic       iRSTN,
    input  logic       iLOCKED,
    input  logic       iSOFT_REQ,
    output logic       oSOFT_ACK,
    output logic [2:0] oRST_N,
    output logic       oREADY,
    output logic [1:0] oSTAGE
);

    // A zero delay behaves as a single cycle.
    localparam int unsigned c_dly0_eff = (DLY0 == 0) ? 1 : DLY0;
    localparam int unsigned c_dly1_eff = (DLY1 == 0) ? 1 : DLY1;
    localparam int unsigned c_dly2_eff = (DLY2 == 0) ? 1 : DLY2;
    localparam int unsigned c_hold_eff = (HOLD_CYC == 0) ? 1 : HOLD_CYC;

    localparam logic [CNT_W-1:0] c_dly0_m1 = CNT_W'(c_dly0_eff - 1);
    localparam logic [CNT_W-1:0] c_dly1_m1 = CNT_W'(c_dly1_eff - 1);
    localparam logic [CNT_W-1:0] c_dly2_m1 = CNT_W'(c_dly2_eff - 1);
    localparam logic [CNT_W-1:0] c_hold_m1 = CNT_W'(c_hold_eff - 1);

    generate
        if (((64'(DLY0) >> CNT_W) != 0) || ((64'(DLY1) >> CNT_W) != 0) ||
            ((64'(DLY2) >> CNT_W) != 0) || ((64'(HOLD_CYC) >> CNT_W) != 0)) begin : g_bad_dly
            $error("reset_sequencer: a delay parameter does not fit in CNT_W bits");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_COUNT     = 3'd1,
        ST_RUN       = 3'd2,
        ST_SOFT_HOLD = 3'd3,
        ST_SOFT_WAIT = 3'd4
    } state_t;

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [1:0]       stage_q,  stage_d;
    logic [2:0]       rst_n_q,  rst_n_d;
    logic             ready_q,  ready_d;
    logic             ack_q,    ack_d;
    logic [1:0]       ostage_q, ostage_d;
    logic [CNT_W-1:0] w_dly_m1;

    always_comb begin
        case (stage_q)
            2'd0:    w_dly_m1 = c_dly0_m1;
            2'd1:    w_dly_m1 = c_dly1_m1;
            default: w_dly_m1 = c_dly2_m1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        rst_n_d = rst_n_q;
        ready_d = ready_q;
        ack_d   = ack_q;

        // Lock loss overrides everything outside WAIT_LOCK, including a pending request.
        if ((state_q != ST_WAIT_LOCK) && !iLOCKED) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            stage_d = 2'd0;
            rst_n_d = 3'b000;
            ready_d = 1'b0;
            ack_d   = 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (iLOCKED) begin
                        state_d = ST_COUNT;
                        cnt_d   = '0;
                        stage_d = 2'd0;
                    end
                end
                ST_COUNT: begin
                    if (cnt_q == w_dly_m1) begin
                        cnt_d = '0;
                        case (stage_q)
                            2'd0: begin
                                rst_n_d = 3'b001;
                                stage_d = 2'd1;
                            end
                            2'd1: begin
                                rst_n_d = 3'b011;
                                stage_d = 2'd2;
                            end
                            default: begin
                                rst_n_d = 3'b111;
                                ready_d = 1'b1;
                                stage_d = 2'd0;
                                state_d = ST_RUN;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (iSOFT_REQ) begin
                        state_d = ST_SOFT_HOLD;
                        cnt_d   = '0;
                        rst_n_d = 3'b000;
                        ready_d = 1'b0;
                    end
                end
                ST_SOFT_HOLD: begin
                    if (cnt_q == c_hold_m1) begin
                        state_d = ST_SOFT_WAIT;
                        cnt_d   = '0;
                        ack_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SOFT_WAIT: begin
                    if (!iSOFT_REQ) begin
                        state_d = ST_COUNT;
                        ack_d   = 1'b0;
                        cnt_d   = '0;
                        stage_d = 2'd0;
                    end
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    stage_d = 2'd0;
                    rst_n_d = 3'b000;
                    ready_d = 1'b0;
                    ack_d   = 1'b0;
                end
            endcase
        end
    end

    // Debug stage index is derived from the next state so it stays registered.
    always_comb begin
        case (state_d)
            ST_COUNT: ostage_d = stage_d;
            ST_RUN:   ostage_d = 2'd3;
            default:  ostage_d = 2'd0;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRSTN) begin
            state_q  <= ST_WAIT_LOCK;
            cnt_q    <= '0;
            stage_q  <= 2'd0;
            rst_n_q  <= 3'b000;
            ready_q  <= 1'b0;
            ack_q    <= 1'b0;
            ostage_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
            rst_n_q  <= rst_n_d;
            ready_q  <= ready_d;
            ack_q    <= ack_d;
            ostage_q <= ostage_d;
        end
    end

    assign oRST_N    = rst_n_q;
    assign oREADY    = ready_q;
    assign oSOFT_ACK = ack_q;
    assign oSTAGE    = ostage_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reset_sequencer
//  Purpose  : Directed self-checking bench for reset_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reset_sequencer;

    logic       clk;
    logic       rstn;
    logic       locked;
    logic       soft_req;
    logic       soft_ack;
    logic [2:0] rst_n;
    logic       ready;
    logic [1:0] stage;

    int n_cmp = 0;
    int n_err = 0;

    reset_sequencer #(
        .CNT_W    (8),
        .DLY0     (4),
        .DLY1     (8),
        .DLY2     (16),
        .HOLD_CYC (5)
    ) u_dut (
        .iCLK      (clk),
        .iRSTN     (rstn),
        .iLOCKED   (locked),
        .iSOFT_REQ (soft_req),
        .oSOFT_ACK (soft_ack),
        .oRST_N    (rst_n),
        .oREADY    (ready),
        .oSTAGE    (stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed observation: {ready, ack, stage[1:0], rst_n[2:0]}
    function automatic logic [6:0] pk(input logic rdy, input logic ack,
                                      input logic [1:0] stg, input logic [2:0] rn);
        return {rdy, ack, stg, rn};
    endfunction

    task automatic chk(input string tag, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (rdy,ack,stage,rst_n)", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] obs();
        return pk(ready, soft_ack, stage, rst_n);
    endfunction

    // Called right after edge t0; checks every edge up to t0+28.
    task automatic run_seq(input string tag);
        logic [2:0] er;
        logic [1:0] es;
        logic       rd;
        for (int k = 1; k <= 28; k++) begin
            tick();
            rd = 1'b0;
            if (k < 4)       begin er = 3'b000; es = 2'd0; end
            else if (k < 12) begin er = 3'b001; es = 2'd1; end
            else if (k < 28) begin er = 3'b011; es = 2'd2; end
            else             begin er = 3'b111; es = 2'd3; rd = 1'b1; end
            chk($sformatf("%s_t0+%0d", tag, k), obs(), pk(rd, 1'b0, es, er));
        end
    endtask

    initial begin
        rstn     = 1'b0;
        locked   = 1'b0;
        soft_req = 1'b0;

        // 1. Power-up with lock arriving at cycle 10
        repeat (3) tick();
        chk("reset_state", obs(), pk(1'b0, 1'b0, 2'd0, 3'b000));
        rstn = 1'b1;
        for (int c = 3; c < 10; c++) begin
            tick();
            chk($sformatf("prelock_c%0d", c), obs(), pk(1'b0, 1'b0, 2'd0, 3'b000));
        end
        locked = 1'b1;
        tick();
        chk("pwr_t0", obs(), pk(1'b0, 1'b0, 2'd0, 3'b000));
        run_seq("pwr");
        tick();
        chk("pwr_run_hold", obs(), pk(1'b1, 1'b0, 2'd3, 3'b111));

        // 2. Late lock after 100 cycles
        rstn   = 1'b0;
        locked = 1'b0;
        tick();
        chk("late_reset", obs(), pk(1'b0, 1'b0, 2'd0, 3'b000));
        rstn = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (obs() !== 7'b0 || c == 99)
                chk($sformatf("late_wait_c%0d", c), obs(), pk(1'b0, 1'b0, 2'd0, 3'b000));
        end
        locked = 1'b1;
        tick();
        chk("late_t0", obs(), pk(1'b0, 1'b0, 2'd0, 3'b000));
        run_seq("late");

        // 3. Soft reset from RUN
        soft_req = 1'b1;
        tick();
        chk("soft_hold_entry", obs(), pk(1'b0, 1'b0, 2'd0, 3'b000));
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("soft_hold_c%0d", c), obs(), pk(1'b0, 1'b0, 2'd0, 3'b000));
        end
        tick();
        chk("soft_ack_rise", obs(), pk(1'b0, 1'b1, 2'd0, 3'b000));
        repeat (3) begin
            tick();
            chk("soft_ack_held", obs(), pk(1'b0, 1'b1, 2'd0, 3'b000));
        end
        soft_req = 1'b0;
        tick();
        chk("soft_ack_fall", obs(), pk(1'b0, 1'b0, 2'd0, 3'b000));
        run_seq("soft");

        // 4. Lock loss while stage 0 is released
        soft_req = 1'b1;
        repeat (6) tick();
        soft_req = 1'b0;
        tick();
        repeat (4) tick();
        chk("ll_stage0_rel", obs(), pk(1'b0, 1'b0, 2'd1, 3'b001));
        locked = 1'b0;
        tick();
        chk("ll_drop", obs(), pk(1'b0, 1'b0, 2'd0, 3'b000));
        repeat (3) begin
            tick();
            chk("ll_waitlock", obs(), pk(1'b0, 1'b0, 2'd0, 3'b000));
        end
        locked = 1'b1;
        tick();
        chk("ll_t0", obs(), pk(1'b0, 1'b0, 2'd0, 3'b000));
        run_seq("relock");

        // 5. Synchronous reset during SOFT_WAIT
        soft_req = 1'b1;
        repeat (6) tick();
        chk("rst_hs_ack", obs(), pk(1'b0, 1'b1, 2'd0, 3'b000));
        rstn = 1'b0;
        tick();
        chk("rst_hs_reset", obs(), pk(1'b0, 1'b0, 2'd0, 3'b000));
        soft_req = 1'b0;
        rstn     = 1'b1;
        tick();
        chk("rst_hs_t0", obs(), pk(1'b0, 1'b0, 2'd0, 3'b000));
        run_seq("rst_hs");

        // 6. Early request during COUNT, then a short (violating) requester
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        soft_req = 1'b1;
        run_seq("early");
        tick();
        chk("early_hold_entry", obs(), pk(1'b0, 1'b0, 2'd0, 3'b000));
        soft_req = 1'b0;
        repeat (4) tick();
        chk("viol_hold", obs(), pk(1'b0, 1'b0, 2'd0, 3'b000));
        tick();
        chk("viol_ack_pulse", obs(), pk(1'b0, 1'b1, 2'd0, 3'b000));
        tick();
        chk("viol_ack_drop", obs(), pk(1'b0, 1'b0, 2'd0, 3'b000));
        run_seq("viol");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
